// File: rtl/airi5c_irq_ctrl.sv
// Interrupt controller: timer_tick (source 0) plus NUM_IRQ external lines, one request to the core,
// claim/complete over HASTI. Define AIRI5C_IRQ_SYNC_EN to put 2-flop synchronizers on ext_irq.
module airi5c_irq_ctrl #(
  parameter logic [31:0] BASE_ADDR         = 32'hC0000020,
  parameter int          NUM_IRQ           = 8,
  parameter int          HASTI_ADDR_WIDTH  = 32,
  parameter int          HASTI_BUS_WIDTH   = 32,
  parameter int          HASTI_SIZE_WIDTH  = 3,
  parameter int          HASTI_BURST_WIDTH = 3,
  parameter int          HASTI_PROT_WIDTH  = 4,
  parameter int          HASTI_TRANS_WIDTH = 2,
  parameter int          HASTI_RESP_WIDTH  = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         timer_tick,
  input  logic [NUM_IRQ-1:0]           ext_irq,
  output logic                         irq_out,
  input  logic [HASTI_ADDR_WIDTH-1:0]  haddr,
  input  logic                         hwrite,
  input  logic [HASTI_SIZE_WIDTH-1:0]  hsize,
  input  logic [HASTI_BURST_WIDTH-1:0] hburst,
  input  logic                         hmastlock,
  input  logic [HASTI_PROT_WIDTH-1:0]  hprot,
  input  logic [HASTI_TRANS_WIDTH-1:0] htrans,
  input  logic [HASTI_BUS_WIDTH-1:0]   hwdata,
  output logic [HASTI_BUS_WIDTH-1:0]   hrdata,
  output logic                         hready,
  output logic [HASTI_RESP_WIDTH-1:0]  hresp
);

  localparam int NSRC = NUM_IRQ + 1;
  localparam int ID_W = 6;

  localparam logic [2:0] OFF_PENDING  = 3'd0;
  localparam logic [2:0] OFF_ENABLE   = 3'd1;
  localparam logic [2:0] OFF_TRIGGER  = 3'd2;
  localparam logic [2:0] OFF_CLAIM    = 3'd3;
  localparam logic [2:0] OFF_COMPLETE = 3'd4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_nx;
  logic [NSRC-1:0]   pending_r;
  logic [NSRC-1:0]   enable_r;
  logic [NSRC-1:0]   trigger_r;
  logic [NSRC-1:0]   prev_r;
  logic [ID_W-1:0]   claimed_r;
  logic              wr_pend_r;
  logic [2:0]        wr_off_r;

  logic [NUM_IRQ-1:0] ext_s;
  logic [NSRC-1:0]    src_s;
  logic [NSRC-1:0]    rise_s;
  logic [NSRC-1:0]    active_s;
  logic [NSRC-1:0]    clr_s;
  logic [4:0]         winner_s;
  logic               found_s;
  logic [ID_W-1:0]    id_s;
  logic [ID_W-1:0]    claim_val_s;
  logic               claim_take_s;
  logic               complete_hit_s;
  logic               sel_s;
  logic               rd_s;
  logic               wr_s;
  logic [2:0]         off_s;
  logic [HASTI_BUS_WIDTH-1:0] rd_word_s;
  logic               unused_bus;

  assign hready     = 1'b1;
  assign hresp      = {HASTI_RESP_WIDTH{1'b0}};
  assign unused_bus = ^{hsize, hburst, hmastlock, hprot, htrans[0], haddr[1:0], hwdata};

`ifdef AIRI5C_IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_r;
  logic [NUM_IRQ-1:0] sync2_r;

  // Two-stage synchronizer for asynchronous external lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= {NUM_IRQ{1'b0}};
      sync2_r <= {NUM_IRQ{1'b0}};
    end else begin
      sync1_r <= ext_irq;
      sync2_r <= sync1_r;
    end
  end

  assign ext_s = sync2_r;
`else
  assign ext_s = ext_irq;
`endif

  // timer_tick is same-domain and never synchronized.
  assign src_s    = {ext_s, timer_tick};
  assign rise_s   = src_s & ~prev_r;
  assign active_s = pending_r & enable_r;

  assign sel_s = (haddr[31:5] == BASE_ADDR[31:5]) && htrans[1];
  assign rd_s  = sel_s && !hwrite;
  assign wr_s  = sel_s && hwrite;
  assign off_s = haddr[4:2];

  // Lowest active index wins; scan downward so the last hit is the lowest.
  always_comb begin
    winner_s = 5'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      winner_s = active_s[i] ? 5'(i) : winner_s;
    end
    found_s = |active_s;
    id_s    = found_s ? ({1'b0, winner_s} + 6'd1) : 6'd0;
  end

  assign complete_hit_s = wr_pend_r && (wr_off_r == OFF_COMPLETE) &&
                          (hwdata[4:0] == claimed_r[4:0]);

  // Claim FSM next state and interrupt request.
  always_comb begin
    state_nx     = state_r;
    irq_out      = 1'b0;
    claim_take_s = 1'b0;
    claim_val_s  = 6'd0;
    case (state_r)
      ST_IDLE: begin
        irq_out     = found_s;
        claim_val_s = id_s;
        if (rd_s && (off_s == OFF_CLAIM) && found_s) begin
          claim_take_s = 1'b1;
          state_nx     = ST_BUSY;
        end else begin
          claim_take_s = 1'b0;
          state_nx     = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (complete_hit_s) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_BUSY;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // One-hot clear for the source being claimed; only edge sources honour it.
  always_comb begin
    clr_s = {NSRC{1'b0}};
    for (int i = 0; i < NSRC; i++) begin
      clr_s[i] = claim_take_s && (winner_s == 5'(i));
    end
  end

  // Read data mux for the address-phase register.
  always_comb begin
    rd_word_s = {HASTI_BUS_WIDTH{1'b0}};
    case (off_s)
      OFF_PENDING: rd_word_s[NSRC-1:0] = pending_r;
      OFF_ENABLE:  rd_word_s[NSRC-1:0] = enable_r;
      OFF_TRIGGER: rd_word_s[NSRC-1:0] = trigger_r;
      OFF_CLAIM:   rd_word_s[ID_W-1:0] = claim_val_s;
      default:     rd_word_s = {HASTI_BUS_WIDTH{1'b0}};
    endcase
  end

  // FSM state and claimed id.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      claimed_r <= 6'd0;
    end else begin
      state_r <= state_nx;
      if (claim_take_s) begin
        claimed_r <= id_s;
      end
    end
  end

  // Source history and pending: edge sources latch (set beats claim clear), level sources follow.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_r    <= {NSRC{1'b0}};
      pending_r <= {NSRC{1'b0}};
    end else begin
      prev_r    <= src_s;
      pending_r <= (trigger_r & (rise_s | (pending_r & ~clr_s))) | (~trigger_r & src_s);
    end
  end

  // Bus pipeline: write offset captured in address phase, data applied in data phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_pend_r <= 1'b0;
      wr_off_r  <= 3'd0;
      hrdata    <= {HASTI_BUS_WIDTH{1'b0}};
    end else begin
      wr_pend_r <= wr_s;
      wr_off_r  <= off_s;
      hrdata    <= rd_s ? rd_word_s : {HASTI_BUS_WIDTH{1'b0}};
    end
  end

  // ENABLE and TRIGGER registers; TRIGGER bit 0 (timer) is always level.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable_r  <= {NSRC{1'b0}};
      trigger_r <= {NSRC{1'b0}};
    end else if (wr_pend_r) begin
      if (wr_off_r == OFF_ENABLE) begin
        enable_r <= hwdata[NSRC-1:0];
      end
      if (wr_off_r == OFF_TRIGGER) begin
        trigger_r <= {hwdata[NSRC-1:1], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_airi5c_irq_ctrl.sv
// Scoreboard bench for airi5c_irq_ctrl: reads push expectations, a monitor checks data phases.
module tb_airi5c_irq_ctrl;

  localparam logic [31:0] BASE    = 32'hC0000020;
  localparam int          NUM_IRQ = 8;
  localparam logic [2:0]  O_PEND  = 3'd0;
  localparam logic [2:0]  O_EN    = 3'd1;
  localparam logic [2:0]  O_TRIG  = 3'd2;
  localparam logic [2:0]  O_CLAIM = 3'd3;
  localparam logic [2:0]  O_COMP  = 3'd4;
`ifdef AIRI5C_IRQ_SYNC_EN
  localparam int SYNC_EXTRA = 2;
`else
  localparam int SYNC_EXTRA = 0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic               timer_tick;
  logic [NUM_IRQ-1:0] ext_irq;
  logic               irq_out;
  logic [31:0]        haddr;
  logic               hwrite;
  logic [2:0]         hsize;
  logic [2:0]         hburst;
  logic               hmastlock;
  logic [3:0]         hprot;
  logic [1:0]         htrans;
  logic [31:0]        hwdata;
  logic [31:0]        hrdata;
  logic               hready;
  logic [0:0]         hresp;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        irq;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  logic rd_seen = 1'b0;

  airi5c_irq_ctrl dut (
    .clk(clk), .reset(reset), .timer_tick(timer_tick), .ext_irq(ext_irq), .irq_out(irq_out),
    .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hmastlock(hmastlock),
    .hprot(hprot), .htrans(htrans), .hwdata(hwdata), .hrdata(hrdata), .hready(hready),
    .hresp(hresp)
  );

  always #5 clk = ~clk;

  // Detect accepted read address phases on the bus.
  always @(posedge clk) begin
    rd_seen <= !reset && htrans[1] && !hwrite && (haddr[31:5] == BASE[31:5]);
  end

  // Monitor: compare each read data phase against the oldest expectation.
  always @(negedge clk) begin
    if (rd_seen) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_read: hrdata=0x%08h with empty scoreboard", hrdata);
      end else begin
        cur = sb.pop_front();
        checks++;
        if (hrdata !== cur.data) begin
          failures++;
          $display("FAIL %s hrdata: got 0x%08h expected 0x%08h", cur.name, hrdata, cur.data);
        end
        checks++;
        if (irq_out !== cur.irq) begin
          failures++;
          $display("FAIL %s irq_out: got %b expected %b", cur.name, irq_out, cur.irq);
        end
        checks++;
        if (hready !== 1'b1 || hresp !== 1'b0) begin
          failures++;
          $display("FAIL %s bus_status: got hready=%b hresp=%b expected 1/0", cur.name, hready, hresp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [2:0] off, input logic [31:0] exp, input logic xirq, input string nm);
    haddr  = BASE + {27'd0, off, 2'b00};
    hwrite = 1'b0;
    htrans = 2'b10;
    sb.push_back('{name: nm, data: exp, irq: xirq});
    @(posedge clk);
    #1;
    htrans = 2'b00;
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] data);
    haddr  = BASE + {27'd0, off, 2'b00};
    hwrite = 1'b1;
    htrans = 2'b10;
    @(posedge clk);
    #1;
    htrans = 2'b00;
    hwrite = 1'b0;
    hwdata = data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    timer_tick = 1'b0;
    ext_irq    = 8'h00;
    haddr      = BASE;
    hwrite     = 1'b0;
    htrans     = 2'b00;
    hwdata     = 32'h0;
    hsize      = 3'b010;
    hburst     = 3'b000;
    hmastlock  = 1'b0;
    hprot      = 4'b0011;
    cyc(3);
    reset = 1'b0;

    // Reset state across the whole window.
    for (int i = 0; i < 8; i++) rd(3'(i), 32'h0, 1'b0, $sformatf("reset_off%0d", i));

    // Timer as level source: claim, then complete while still asserted.
    wr(O_EN, 32'h1);
    timer_tick = 1'b1;
    cyc(1);
    rd(O_PEND,  32'h1, 1'b1, "tick_pending");
    rd(O_CLAIM, 32'h1, 1'b0, "tick_claim");
    rd(O_PEND,  32'h1, 1'b0, "tick_busy_pending");
    wr(O_COMP,  32'h1);
    rd(O_PEND,  32'h1, 1'b1, "tick_after_complete");
    timer_tick = 1'b0;
    cyc(1);

    // Two edge sources pulsed together.
    wr(O_EN,   32'h6);
    wr(O_TRIG, 32'h6);
    ext_irq = 8'h03;
    cyc(1);
    ext_irq = 8'h00;
    cyc(SYNC_EXTRA);
    rd(O_PEND,  32'h6, 1'b1, "edge_pending");
    rd(O_CLAIM, 32'h2, 1'b0, "edge_claim2");
    rd(O_PEND,  32'h4, 1'b0, "edge_pending_after_claim");
    wr(O_COMP,  32'h5);
    rd(O_PEND,  32'h4, 1'b0, "wrong_complete_ignored");
    rd(O_CLAIM, 32'h0, 1'b0, "busy_claim_zero");
    wr(O_COMP,  32'h2);
    rd(O_CLAIM, 32'h3, 1'b0, "edge_claim3");
    rd(O_PEND,  32'h0, 1'b0, "edge_pending_empty");
    wr(O_COMP,  32'h3);
    rd(O_PEND,  32'h0, 1'b0, "idle_no_active");

    // New edge arriving in the claim cycle survives the claim clear.
    ext_irq = 8'h01;
    cyc(1);
    ext_irq = 8'h00;
    cyc(SYNC_EXTRA + 2);
    ext_irq = 8'h01;
    cyc(SYNC_EXTRA);
    rd(O_CLAIM, 32'h2, 1'b0, "race_claim");
    ext_irq = 8'h00;
    rd(O_PEND,  32'h2, 1'b0, "race_set_wins");
    wr(O_COMP,  32'h2);
    rd(O_CLAIM, 32'h2, 1'b0, "race_reclaim");
    wr(O_COMP,  32'h2);
    cyc(SYNC_EXTRA);
    rd(O_PEND,  32'h0, 1'b0, "race_cleared");

    // Masked pending source: no request, no claim, pending kept.
    wr(O_EN, 32'h0);
    ext_irq = 8'h01;
    cyc(1);
    ext_irq = 8'h00;
    cyc(SYNC_EXTRA);
    rd(O_PEND,  32'h2, 1'b0, "masked_pending");
    rd(O_CLAIM, 32'h0, 1'b0, "masked_claim_zero");
    rd(O_PEND,  32'h2, 1'b0, "masked_pending_kept");
    wr(O_EN,    32'h2);
    rd(O_PEND,  32'h2, 1'b1, "unmasked_irq");
    rd(O_EN,    32'h2, 1'b1, "enable_readback");
    wr(O_TRIG,  32'hFFFF_FFFF);
    rd(O_TRIG,  32'h0000_01FE, 1'b1, "trigger_bit_limits");
    wr(3'd5,    32'hFFFF_FFFF);
    rd(3'd5,    32'h0, 1'b1, "reserved_reads_zero");

    // Enter BUSY with PENDING=0x3, then reset during a write data phase.
    timer_tick = 1'b1;
    wr(O_EN, 32'h3);
    rd(O_PEND,  32'h3, 1'b1, "pre_reset_pending");
    rd(O_CLAIM, 32'h1, 1'b0, "pre_reset_claim");
    rd(O_PEND,  32'h3, 1'b0, "pre_reset_busy");
    haddr  = BASE + 32'h4;
    hwrite = 1'b1;
    htrans = 2'b10;
    cyc(1);
    htrans     = 2'b00;
    hwrite     = 1'b0;
    hwdata     = 32'hFF;
    reset      = 1'b1;
    timer_tick = 1'b0;
    cyc(2);
    reset = 1'b0;
    rd(O_PEND,  32'h0, 1'b0, "post_reset_pending");
    rd(O_EN,    32'h0, 1'b0, "post_reset_enable");
    rd(O_TRIG,  32'h0, 1'b0, "post_reset_trigger");
    rd(O_CLAIM, 32'h0, 1'b0, "post_reset_claim");
    wr(O_EN, 32'h1);
    timer_tick = 1'b1;
    cyc(1);
    rd(O_PEND,  32'h1, 1'b1, "post_reset_idle_irq");
    rd(O_CLAIM, 32'h1, 1'b0, "post_reset_claim_tick");
    timer_tick = 1'b0;
    wr(O_COMP, 32'h1);

    cyc(2);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/airi5c_irq_ctrl.md
Name: airi5c_irq_ctrl

Overview:
- Interrupt controller downstream of the system timer.
- Consumes timer_tick as source 0 and NUM_IRQ external lines as sources 1..NUM_IRQ.
- Latches, masks and prioritises these sources, and drives one interrupt request to the core.
- Claim/complete handshake runs over the same HASTI (AHB-lite) slave bus as the timer.

Parameters:
BASE_ADDR, 32'hC0000020, base of 32-byte register window; decode on haddr[31:5].
NUM_IRQ, 8, number of external sources (1..31); total sources NSRC = NUM_IRQ+1.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
timer_tick  input  1  level interrupt from timer (source 0, same clock domain)
ext_irq  input  NUM_IRQ  external interrupt lines (sources 1..NUM_IRQ)
irq_out  output  1  interrupt request to core
haddr  input  HASTI_ADDR_WIDTH  bus address
hwrite  input  1  write flag
hsize  input  HASTI_SIZE_WIDTH  unused, word access only
hburst  input  HASTI_BURST_WIDTH  unused
hmastlock  input  1  unused
hprot  input  HASTI_PROT_WIDTH  unused
htrans  input  HASTI_TRANS_WIDTH  transfer type
hwdata  input  HASTI_BUS_WIDTH  write data
hrdata  output  HASTI_BUS_WIDTH  read data (registered)
hready  output  1  constant 1
hresp  output  HASTI_RESP_WIDTH  constant OKAY

Behaviour:
- Register map, offset = haddr[4:2]*4:
  - 0x00 PENDING: RO.
  - 0x04 ENABLE: RW.
  - 0x08 TRIGGER: RW; 1 = edge, 0 = level; bit0 hardwired 0.
  - 0x0C CLAIM: RO with side effect.
  - 0x10 COMPLETE: WO.
  - 0x14–0x1C: reserved; read 0, writes ignored.
  - Bits >= NSRC: read 0, writes ignored.
- Bus timing:
  - Address phase is accepted when the haddr match is true and htrans[1]=1 (NONSEQ/SEQ).
  - Read: hrdata is registered at the end of the address phase and valid in the data phase (zero wait states).
  - Write: offset is captured in the address phase; hwdata is applied at the end of the following cycle.
- Source conditioning:
  - ext_irq passes through the sync path (see Optional Feature), giving s[i].
  - prev[i] is s[i] delayed one cycle.
  - edge[i] = s[i] & ~prev[i].
- Pending update each cycle:
  - Level source: pending[i] <= s[i].
  - Edge source: pending[i] is set by edge[i]; cleared when a claim returns id i+1.
  - Set and clear in the same cycle: set wins.
  - A TRIGGER change takes effect next cycle.
  - Level to edge: current pending is kept.
  - Edge to level: pending tracks the input from then on.
- Selection:
  - active = pending & ENABLE.
  - winner = lowest set index of active.
  - id = winner+1, or 0 if none.
- FSM, two states:
  - IDLE:
    - irq_out = |active.
    - An accepted CLAIM read returns id in hrdata.
    - If id != 0: record claimed_id and go to BUSY; if the source is edge type, clear its pending.
    - If id == 0: return 0 and stay in IDLE.
  - BUSY:
    - irq_out = 0 (no nesting).
    - CLAIM read returns 0 with no side effect.
    - A COMPLETE write with hwdata[4:0] == claimed_id returns to IDLE next cycle.
    - A COMPLETE write with any other value is ignored.
  - COMPLETE in IDLE: ignored.
- irq_out timing: derived only from registered state (pending, ENABLE, FSM); combinational path to the output only, no path from bus inputs.
- Masking: clearing an ENABLE bit masks the source but keeps its pending bit. Disabling the claimed source while BUSY does not leave BUSY.
- Reset values:
  - PENDING, ENABLE, TRIGGER, sync/prev flops, claimed_id: 0.
  - hrdata: 0; irq_out: 0.
  - FSM: IDLE.
- Reset mid-operation (including in BUSY, or mid bus transfer): immediately returns to the reset state; an in-flight write is discarded.

Optional Feature:
- Macro: AIRI5C_IRQ_SYNC_EN.
- Defined:
  - Each ext_irq bit passes through a 2-flop synchronizer before prev/edge logic.
  - A rise sampled at clock edge k shows in PENDING after edge k+2.
- Undefined:
  - s = ext_irq directly; the rise shows after edge k.
  - For synchronous sources only.
- timer_tick is never synchronized in either configuration.

Test Plan:
- Reset, then read all offsets -> 0; irq_out=0; hready=1; hresp=OKAY.
- ENABLE=0x1, TRIGGER=0x0, timer_tick=1 -> irq_out=1. Read CLAIM -> 1; irq_out=0. Write COMPLETE=1 while timer_tick still 1 -> irq_out=1 again the next cycle.
- ENABLE=0x6, TRIGGER=0x6, single-cycle pulses on ext_irq[0] and ext_irq[1] in the same cycle (sync defined) -> PENDING=0x6 after 2 cycles.
  - CLAIM -> 2, PENDING=0x4.
  - COMPLETE=5 ignored, irq_out stays 0.
  - COMPLETE=2 -> CLAIM -> 3, PENDING=0.
- Edge source claimed while a new edge arrives in the claim cycle -> pending stays 1. After complete, CLAIM returns the same id again.
- ENABLE=0, PENDING=0x2 -> irq_out=0 and CLAIM returns 0 with the FSM still IDLE. Then ENABLE=0x2 -> irq_out=1.
- Assert reset while BUSY with PENDING=0x3 -> all registers 0, FSM IDLE, irq_out=0. The first CLAIM after release (sources inactive) returns 0.
